// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: IEEE 1149.1 TAP states, sequencer op/state encodings
// and the TAP next-state function used by both tap_ctrl and the sequencer.
package jtag_types_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR        = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR        = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } state_t;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_IR_SCAN = 2'd2,
    OP_DR_SCAN = 2'd3
  } seq_op_t;

  typedef enum logic [2:0] {
    SQ_IDLE, SQ_PRE, SQ_NAV, SQ_SHIFT, SQ_POST, SQ_WAIT, SQ_RST, SQ_RSP
  } seq_state_t;

  localparam int RESET_TMS_CYCLES = 5;

  function automatic state_t tap_next(input state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        return tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       return tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         return tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         return tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         return tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         return tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        return tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         return tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         return tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         return tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         return tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        return tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          return TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/tap_state_model.sv
// Registered mirror of the target TAP controller state, driven by the same
// TMS stream the TAP sees.
module tap_state_model
  import jtag_types_pkg::*;
(
  input  logic   TCK,
  input  logic   TRST,
  input  logic   TMS,
  output state_t state
);

  always_ff @(posedge TCK) begin
    if (TRST) state <= TEST_LOGIC_RESET;
    else      state <= tap_next(state, TMS);
  end

endmodule

// File: rtl/jtag_tap_sequencer.sv
// Command engine that walks a JTAG TAP along fixed TMS paths, shifts TDI
// payloads LSB-first and returns captured TDO over a valid/ready response.
module jtag_tap_sequencer
  import jtag_types_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output state_t             tap_state,
  output logic               busy
);

  seq_state_t         seq_reg, seq_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  seq_op_t            op_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [MAX_LEN-1:0] data_reg;
  logic [MAX_LEN-1:0] cap_reg;
  logic               err_reg;
  logic               tms_reg, tms_next;
  logic               tdi_reg, tdi_next;
  state_t             tap_nxt;
  logic               accept, len_ok, is_scan, tlr_next;

  tap_state_model u_tap (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (tms_reg),
    .state (tap_state)
  );

  // TAP state that will hold after the current edge; all TMS decisions use it
  assign tap_nxt  = tap_next(tap_state, tms_reg);
  assign tlr_next = (tap_nxt == TEST_LOGIC_RESET);
  assign accept   = cmd_valid && cmd_ready;
  assign is_scan  = cmd_op[1];
  assign len_ok   = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));

  always_ff @(posedge TCK) begin
    if (TRST) begin
      seq_reg  <= SQ_IDLE;
      cnt_reg  <= '0;
      tms_reg  <= 1'b1;
      tdi_reg  <= 1'b0;
      op_reg   <= OP_RESET;
      len_reg  <= '0;
      data_reg <= '0;
      cap_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      seq_reg <= seq_next;
      cnt_reg <= cnt_next;
      tms_reg <= tms_next;
      tdi_reg <= tdi_next;
      if (accept) begin
        op_reg   <= seq_op_t'(cmd_op);
        len_reg  <= cmd_len;
        data_reg <= cmd_data;
        cap_reg  <= '0;
        err_reg  <= is_scan && !len_ok;
      end else if (seq_reg == SQ_SHIFT &&
                   (tap_state == SHIFT_DR || tap_state == SHIFT_IR)) begin
        cap_reg <= cap_reg | (MAX_LEN'(TDO) << cnt_reg);
      end
    end
  end

  always_comb begin
    seq_next = seq_reg;
    cnt_next = cnt_reg;
    case (seq_reg)
      SQ_IDLE: begin
        cnt_next = '0;
        if (accept) begin
          case (seq_op_t'(cmd_op))
            OP_RESET: seq_next = SQ_RST;
            OP_IDLE:  seq_next = (cmd_len == '0) ? SQ_RSP : (tlr_next ? SQ_PRE : SQ_WAIT);
            default:  seq_next = !len_ok ? SQ_RSP : (tlr_next ? SQ_PRE : SQ_NAV);
          endcase
        end
      end
      SQ_PRE: begin
        cnt_next = '0;
        seq_next = (op_reg == OP_IDLE) ? SQ_WAIT : SQ_NAV;
      end
      SQ_NAV: begin
        if (cnt_reg == ((op_reg == OP_IR_SCAN) ? LEN_W'(3) : LEN_W'(2))) begin
          seq_next = SQ_SHIFT;
          cnt_next = '0;
        end else cnt_next = cnt_reg + 1'b1;
      end
      SQ_SHIFT: begin
        if (cnt_reg == len_reg - 1'b1) begin
          seq_next = SQ_POST;
          cnt_next = '0;
        end else cnt_next = cnt_reg + 1'b1;
      end
      SQ_POST: begin
        if (cnt_reg == LEN_W'(1)) seq_next = SQ_RSP;
        else                      cnt_next = cnt_reg + 1'b1;
      end
      SQ_WAIT: begin
        if (cnt_reg == len_reg - 1'b1) seq_next = SQ_RSP;
        else                           cnt_next = cnt_reg + 1'b1;
      end
      SQ_RST: begin
        if (cnt_reg == LEN_W'(RESET_TMS_CYCLES - 1)) seq_next = SQ_RSP;
        else                                          cnt_next = cnt_reg + 1'b1;
      end
      SQ_RSP:  if (rsp_ready) seq_next = SQ_IDLE;
      default: seq_next = SQ_IDLE;
    endcase
  end

  // TMS/TDI are registered, so they are derived from the state being entered
  always_comb begin
    tms_next = tlr_next;
    tdi_next = 1'b0;
    case (seq_next)
      SQ_PRE:   tms_next = 1'b0;
      SQ_NAV:   tms_next = (cnt_next == '0) ||
                           (op_reg == OP_IR_SCAN && cnt_next == LEN_W'(1));
      SQ_SHIFT: begin
        tms_next = (cnt_next == len_reg - 1'b1);
        tdi_next = |(data_reg & (MAX_LEN'(1) << cnt_next));
      end
      SQ_POST:  tms_next = (cnt_next == '0);
      SQ_WAIT:  tms_next = 1'b0;
      SQ_RST:   tms_next = 1'b1;
      default:  tms_next = tlr_next;
    endcase
  end

  assign cmd_ready = (seq_reg == SQ_IDLE);
  assign rsp_valid = (seq_reg == SQ_RSP);
  assign busy      = (seq_reg != SQ_IDLE);
  assign rsp_data  = cap_reg;
  assign rsp_err   = err_reg;
  assign TMS       = tms_reg;
  assign TDI       = tdi_reg;

endmodule
